// File: rtl/operand_loader_pkg.sv
// operand_loader shared types: loader state encoding and default width.
// 2'd3 is unreachable; the FSM treats it as LD_A.
package operand_loader_pkg;

  localparam int OPW = 8;

  typedef enum logic [1:0] {
    LD_A    = 2'd0,
    LD_B    = 2'd1,
    LD_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/operand_loader_if.sv
// Serial-in / parallel-out bus of the operand loader.
// master = feeder and consumer side, slave = the loader itself.
interface operand_loader_if
  import operand_loader_pkg::*;
#(
  parameter int W = OPW
);

  logic         sin;
  logic         sin_valid;
  logic         sin_ready;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   pair_cnt;

  modport master (
    output sin, sin_valid, out_ready,
    input  sin_ready, a_out, b_out,
    input  out_valid, pair_cnt
  );

  modport slave (
    input  sin, sin_valid, out_ready,
    output sin_ready, a_out, b_out,
    output out_valid, pair_cnt
  );

endinterface

// File: rtl/and8b.sv
// 8-bit bitwise AND stage fed by operand_loader.
// Purely combinational.
module and8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] f
);

  assign f = a & b;

endmodule

// File: rtl/operand_loader_sipo.sv
// W-bit serial-in/parallel-out shift register, MSB first.
// Shared by the A and B phases of the loader.
module sipo_w
  import operand_loader_pkg::*;
#(
  parameter int W = OPW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= {q[W-2:0], din};
  end

endmodule

// File: rtl/operand_loader.sv
// Serial front end: assembles A then B MSB first and presents the pair
// with a valid/ready handshake; counts completed handshakes.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int W = OPW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  operand_loader_if.slave bus
);

  localparam int CW = $clog2(W);

  state_t         state;
  state_t         nxt;
  logic [CW-1:0]  bcnt;
  logic [W-1:0]   sh;
  logic [W-1:0]   sh_nxt;
  logic [W-1:0]   a_stg;
  logic           take;
  logic           last;
  logic           hs;
  logic           done_a;
  logic           done_b;

  // ready is a pure state decode, never a path from out_ready
  assign bus.sin_ready = (state != LD_HOLD);
  assign take   = bus.sin_valid && bus.sin_ready;
  assign last   = (bcnt == CW'(W - 1));
  assign sh_nxt = {sh[W-2:0], bus.sin};
  assign hs     = bus.out_valid && bus.out_ready;

  sipo_w #(.W(W)) u_sipo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (take),
    .din  (bus.sin),
    .q    (sh)
  );

  always_comb begin
    nxt    = LD_A;
    done_a = 1'b0;
    done_b = 1'b0;
    unique case (1'b1)
      (state == LD_B): begin
        nxt = LD_B;
        if (take && last) begin
          done_b = 1'b1;
          nxt    = LD_HOLD;
        end
      end
      (state == LD_HOLD): begin
        nxt = hs ? LD_A : LD_HOLD;
      end
      default: begin
        if (take && last) begin
          done_a = 1'b1;
          nxt    = LD_B;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= LD_A;
    else if (clr) state <= LD_A;
    else          state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt          <= '0;
      a_stg         <= '0;
      bus.a_out     <= '0;
      bus.b_out     <= '0;
      bus.out_valid <= 1'b0;
      bus.pair_cnt  <= 8'd0;
    end else if (clr) begin
      bcnt          <= '0;
      a_stg         <= '0;
      bus.a_out     <= '0;
      bus.b_out     <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (take)
        bcnt <= last ? '0 : bcnt + 1'b1;
      if (done_a)
        a_stg <= sh_nxt;
      if (done_b) begin
        bus.a_out     <= a_stg;
        bus.b_out     <= sh_nxt;
        bus.out_valid <= 1'b1;
      end
      if (hs) begin
        bus.out_valid <= 1'b0;
        bus.pair_cnt  <= bus.pair_cnt + 8'd1;
      end
    end
  end

endmodule
